// File: rtl/ram_clr_sp.sv
// ram_clr_sp: single-port synchronous RAM with a registered read port and a
// one-word-per-cycle clear engine that rejects accesses while it runs.
module ram_clr_sp #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [DATA_W-1:0] CLR_VAL    = '0,
  parameter int unsigned       RD_MODE    = 0,
  parameter int unsigned       CLR_ON_RST = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr_start,
  input  logic              rd_ram,
  input  logic              wr_ram,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] data_in_ram,
  output logic [DATA_W-1:0] data_out_ram,
  output logic              rd_valid,
  output logic              busy,
  output logic              rej
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLR_ON_RST != 0) ? CLEAR : IDLE;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rej_q, rej_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    rd_valid_d = 1'b0;
    rej_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = ram_addr;
    mem_wdata  = data_in_ram;

    case (state_q)
      IDLE: begin
        mem_we = wr_ram;
        if (rd_ram) begin
          rd_valid_d = 1'b1;
          // Write-first mode forwards the incoming word on a same-cycle rd+wr.
          if (wr_ram && (RD_MODE != 0)) begin
            dout_d = data_in_ram;
          end else begin
            dout_d = mem[ram_addr];
          end
        end
        if (clr_start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = CLR_VAL;
        cnt_d     = cnt_q + 1'b1;
        rej_d     = rd_ram | wr_ram;
        if (cnt_q == '1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  // The array has no reset so it stays mappable to block RAM.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      rej_q      <= rej_d;
    end
  end

  assign data_out_ram = dout_q;
  assign rd_valid     = rd_valid_q;
  assign rej          = rej_q;
  assign busy         = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_clr_sp.sv
// Bench for ram_clr_sp: two instances (8x256 read-first, 16x16 write-first)
// driven in lockstep and scored against an array-level model of the RAM.
module tb_ram_clr_sp;

  logic        clock = 1'b0;
  logic        reset;
  logic        clr_start, rd_ram, wr_ram;
  logic [7:0]  addr;
  logic [7:0]  din_a;
  logic [15:0] din_b;

  logic [7:0]  dout_a;
  logic        rdv_a, busy_a, rej_a;
  logic [15:0] dout_b;
  logic        rdv_b, busy_b, rej_b;

  always #5 clock = ~clock;

  ram_clr_sp #(
    .DATA_W(8), .ADDR_W(8), .CLR_VAL(8'h00), .RD_MODE(0), .CLR_ON_RST(1)
  ) dut_a (
    .clock(clock), .reset(reset), .clr_start(clr_start),
    .rd_ram(rd_ram), .wr_ram(wr_ram), .ram_addr(addr),
    .data_in_ram(din_a), .data_out_ram(dout_a),
    .rd_valid(rdv_a), .busy(busy_a), .rej(rej_a)
  );

  ram_clr_sp #(
    .DATA_W(16), .ADDR_W(4), .CLR_VAL(16'hFFFF), .RD_MODE(1), .CLR_ON_RST(1)
  ) dut_b (
    .clock(clock), .reset(reset), .clr_start(clr_start),
    .rd_ram(rd_ram), .wr_ram(wr_ram), .ram_addr(addr[3:0]),
    .data_in_ram(din_b), .data_out_ram(dout_b),
    .rd_valid(rdv_b), .busy(busy_b), .rej(rej_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        busy;
    logic        rej;
    logic        rdv;
    logic [15:0] dout;
  } status_t;

  status_t     stq_a[$], stq_b[$];
  logic [15:0] rdq_a[$], rdq_b[$];
  status_t     sa, sb;

  // Reference model: the array as plain words plus "cycles of clear left".
  // Nothing is observable during a clear, so the array is wiped at once.
  logic [15:0] m_mem    [2][256];
  int          m_rem    [2];
  logic [15:0] m_dout   [2];
  int          m_depth  [2] = '{256, 16};
  logic [15:0] m_clr    [2] = '{16'h0000, 16'hFFFF};
  int          m_rdmode [2] = '{0, 1};

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int d, input logic rst_i, input logic clr_i,
                            input logic rd_i, input logic wr_i,
                            input int a, input logic [15:0] dat);
    status_t s;
    s = '0;
    if (!rst_i) begin
      m_rem[d]  = m_depth[d];
      m_dout[d] = '0;
      for (int i = 0; i < m_depth[d]; i++) m_mem[d][i] = m_clr[d];
    end else if (m_rem[d] > 0) begin
      s.rej = rd_i | wr_i;
      m_rem[d]--;
    end else begin
      if (rd_i) begin
        m_dout[d] = (wr_i && m_rdmode[d] == 1) ? dat : m_mem[d][a];
        s.rdv = 1'b1;
        if (d == 0) rdq_a.push_back(m_dout[d]);
        else        rdq_b.push_back(m_dout[d]);
      end
      if (wr_i) m_mem[d][a] = dat;
      if (clr_i) begin
        m_rem[d] = m_depth[d];
        for (int i = 0; i < m_depth[d]; i++) m_mem[d][i] = m_clr[d];
      end
    end
    s.busy = (m_rem[d] > 0);
    s.dout = m_dout[d];
    if (d == 0) stq_a.push_back(s);
    else        stq_b.push_back(s);
  endtask

  task automatic apply_stimulus(input logic rst_i, input logic clr_i, input logic rd_i,
                                input logic wr_i, input logic [7:0] a,
                                input logic [7:0] da, input logic [15:0] db);
    @(negedge clock);
    reset     = rst_i;
    clr_start = clr_i;
    rd_ram    = rd_i;
    wr_ram    = wr_i;
    addr      = a;
    din_a     = da;
    din_b     = db;
    model_step(0, rst_i, clr_i, rd_i, wr_i, int'(a), {8'h00, da});
    model_step(1, rst_i, clr_i, rd_i, wr_i, int'(a[3:0]), db);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
  endtask

  task automatic rd(input logic [7:0] a);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, a, 8'h00, 16'h0000);
  endtask

  always @(posedge clock) begin
    #1;
    if (stq_a.size() > 0) begin
      sa = stq_a.pop_front();
      check_output("a_busy", {15'b0, busy_a}, {15'b0, sa.busy});
      check_output("a_rej", {15'b0, rej_a}, {15'b0, sa.rej});
      check_output("a_rd_valid", {15'b0, rdv_a}, {15'b0, sa.rdv});
      if (rdv_a) begin
        if (rdq_a.size() == 0) check_output("a_rd_unexpected", {15'b0, rdv_a}, 16'd0);
        else                   check_output("a_rd_data", {8'h00, dout_a}, rdq_a.pop_front());
      end else begin
        check_output("a_dout_hold", {8'h00, dout_a}, sa.dout);
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (stq_b.size() > 0) begin
      sb = stq_b.pop_front();
      check_output("b_busy", {15'b0, busy_b}, {15'b0, sb.busy});
      check_output("b_rej", {15'b0, rej_b}, {15'b0, sb.rej});
      check_output("b_rd_valid", {15'b0, rdv_b}, {15'b0, sb.rdv});
      if (rdv_b) begin
        if (rdq_b.size() == 0) check_output("b_rd_unexpected", {15'b0, rdv_b}, 16'd0);
        else                   check_output("b_rd_data", dout_b, rdq_b.pop_front());
      end else begin
        check_output("b_dout_hold", dout_b, sb.dout);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] ra;
    reset = 1'b0; clr_start = 1'b0; rd_ram = 1'b0; wr_ram = 1'b0;
    addr = '0; din_a = '0; din_b = '0;

    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
    // Power-up clear of the big array; every access in this window is rejected.
    for (int i = 0; i < 256; i++)
      apply_stimulus(1'b1, 1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     8'($urandom), 8'($urandom), 16'($urandom));
    rd(8'h00); rd(8'h7F); rd(8'hFF);
    idle(2);

    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'hA5, 16'hA5A5);
    rd(8'h10);
    idle(3);

    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 8'h11, 16'h0011);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 8'h22, 16'h0022);
    rd(8'h20);
    idle(2);

    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h05, 8'h33, 16'h0033);
    idle(4);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h77, 16'h7777);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
    idle(254);
    rd(8'h05);
    idle(2);

    // Reset lands 100 words into a clear, with strobes held high meanwhile.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
    idle(100);
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 8'h55, 16'h5555);
    idle(256);
    rd(8'h40);
    idle(1);

    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, 8'h12, 16'h1234);
    rd(8'h0F);
    rd(8'h03);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      apply_stimulus(1'b1, ($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 1) == 1), ra, 8'($urandom), 16'($urandom));
    end
    idle(3);

    check_output("a_queue_drained", 16'(rdq_a.size()), 16'd0);
    check_output("b_queue_drained", 16'(rdq_b.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
